// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Writeback arbiter driving the single write port of reg_file.
//   The ALU path is single-cycle and never stalls; it always wins the port.
//   Long-latency (LU) results are queued in a DEPTH-entry FIFO and drain in
//   cycles where the ALU has no real write. A queued LU result whose
//   destination has since been written by a younger ALU result is squashed
//   (popped without a write) to keep write-after-write order.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   alu_valid/rd/data       ALU result (rd==0 means no request)
//   lu_valid/rd/data        LU result offer; lu_ready is the registered !full
//   write_reg/data/enable   registered outputs to reg_file
//   lu_count                FIFO occupancy
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [ADDR_W-1:0]        lu_rd,
  input  logic [DATA_W-1:0]        lu_data,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  output logic                     write_reg_enable,
  output logic [$clog2(DEPTH):0]   lu_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [ADDR_W-1:0] rd_mem_d   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [DEPTH-1:0]  kill_q, kill_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              lu_ready_q, lu_ready_d;

  // Output registers
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              write_en_q, write_en_d;

  // Per-cycle decisions
  logic alu_sel_s;
  logic empty_s;
  logic push_s;
  logic pop_s;

  // Select the writer for this cycle and decide push/pop.
  always_comb begin
    alu_sel_s = alu_valid && (alu_rd != {ADDR_W{1'b0}});
    empty_s   = (count_q == {CNT_W{1'b0}});
    // lu_ready_q already guarantees room, so a push never needs the pop.
    push_s    = lu_valid && lu_ready_q && (lu_rd != {ADDR_W{1'b0}});
    pop_s     = !alu_sel_s && !empty_s;
  end

  // Next-state for FIFO contents, kill bits, pointers, occupancy.
  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    kill_d     = kill_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    // Younger ALU write to rd X kills every older queued entry targeting X.
    // Free slots may get marked too; a push always clears the bit again.
    if (alu_sel_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        kill_d[i] = kill_q[i] | (rd_mem_q[i] == alu_rd);
      end
    end else begin
      kill_d = kill_q;
    end

    // Same-cycle push is younger than the ALU write, so it lands un-killed.
    if (push_s) begin
      rd_mem_d[wr_ptr_q]   = lu_rd;
      data_mem_d[wr_ptr_q] = lu_data;
      kill_d[wr_ptr_q]     = 1'b0;
      wr_ptr_d             = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase

    lu_ready_d = (count_d != CNT_W'(DEPTH));
  end

  // Next-state for the registered reg_file write port.
  always_comb begin
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    write_en_d   = 1'b0;
    if (alu_sel_s) begin
      write_en_d   = 1'b1;
      write_reg_d  = alu_rd;
      write_data_d = alu_data;
    end else if (pop_s) begin
      // A killed head is retired silently; address/data simply hold.
      if (!kill_q[rd_ptr_q]) begin
        write_en_d   = 1'b1;
        write_reg_d  = rd_mem_q[rd_ptr_q];
        write_data_d = data_mem_q[rd_ptr_q];
      end else begin
        write_en_d = 1'b0;
      end
    end else begin
      write_en_d = 1'b0;
    end
  end

  // State and output registers; reset discards every queued result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= {ADDR_W{1'b0}};
        data_mem_q[i] <= {DATA_W{1'b0}};
      end
      kill_q       <= {DEPTH{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      lu_ready_q   <= 1'b0;
      write_reg_q  <= {ADDR_W{1'b0}};
      write_data_q <= {DATA_W{1'b0}};
      write_en_q   <= 1'b0;
    end else begin
      rd_mem_q     <= rd_mem_d;
      data_mem_q   <= data_mem_d;
      kill_q       <= kill_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      lu_ready_q   <= lu_ready_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      write_en_q   <= write_en_d;
    end
  end

  assign lu_ready         = lu_ready_q;
  assign lu_count         = count_q;
  assign write_reg        = write_reg_q;
  assign write_data       = write_data_q;
  assign write_reg_enable = write_en_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//   Directed scenarios plus a randomized run against a queue-based reference
//   model of the writeback arbiter.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;

  logic              clk;
  logic              rst_n;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_rd;
  logic [DATA_W-1:0] lu_data;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              write_reg_enable;
  logic [$clog2(DEPTH):0] lu_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of pending LU results with a kill flag each.
  logic [ADDR_W-1:0] q_rd[$];
  logic [DATA_W-1:0] q_data[$];
  bit                q_kill[$];
  logic              exp_we;
  logic [ADDR_W-1:0] exp_reg;
  logic [DATA_W-1:0] exp_data;
  logic              exp_ready;

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .write_reg(write_reg), .write_data(write_data),
    .write_reg_enable(write_reg_enable), .lu_count(lu_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q_rd.delete(); q_data.delete(); q_kill.delete();
    exp_we = 1'b0; exp_reg = '0; exp_data = '0; exp_ready = 1'b0;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
  endtask

  // Apply the arbitration rules to the current inputs, then advance one edge.
  task automatic step();
    if (alu_valid && alu_rd != 0) begin
      exp_we = 1'b1; exp_reg = alu_rd; exp_data = alu_data;
      foreach (q_rd[i]) if (q_rd[i] == alu_rd) q_kill[i] = 1'b1;
    end else if (q_rd.size() > 0) begin
      exp_we = !q_kill[0];
      if (!q_kill[0]) begin exp_reg = q_rd[0]; exp_data = q_data[0]; end
      void'(q_rd.pop_front()); void'(q_data.pop_front()); void'(q_kill.pop_front());
    end else begin
      exp_we = 1'b0;
    end
    if (lu_valid && exp_ready && lu_rd != 0) begin
      q_rd.push_back(lu_rd); q_data.push_back(lu_data); q_kill.push_back(1'b0);
    end
    exp_ready = (q_rd.size() < DEPTH);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); model_reset();
    #12;
    checks++; if (write_reg_enable !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
      failures++; $display("FAIL reset_outputs got we=%0b reg=%0d data=%h exp 0/0/0", write_reg_enable, write_reg, write_data); end
    checks++; if (lu_count !== 2'd0 || lu_ready !== 1'b0) begin
      failures++; $display("FAIL reset_fifo got count=%0d ready=%0b exp 0/0", lu_count, lu_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
    step();
    checks++; if (lu_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready_rise got=%0b exp=1", lu_ready); end
    // Queue two entries while the ALU holds the port.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA5A5_0009;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h0000_0033; step();
    lu_rd = 5'd4; lu_data = 32'h0000_0044; step();
    idle_inputs();
    checks++; if (lu_count !== 2'd2) begin
      failures++; $display("FAIL reset_prefill got count=%0d exp=2", lu_count); end
    #2; rst_n = 1'b0; #1;
    checks++; if (write_reg_enable !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0 ||
                  lu_count !== 2'd0 || lu_ready !== 1'b0) begin
      failures++; $display("FAIL reset_midop got we=%0b reg=%0d data=%h count=%0d ready=%0b exp all 0",
                           write_reg_enable, write_reg, write_data, lu_count, lu_ready); end
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (write_reg_enable !== 1'b0 || lu_count !== 2'd0) begin
        failures++; $display("FAIL reset_no_write cyc=%0d got we=%0b count=%0d exp 0/0", i, write_reg_enable, lu_count); end
    end
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF; step(); idle_inputs();
    checks++; if (write_reg_enable !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL alu_only got we=%0b reg=%0d data=%h exp 1/5/deadbeef", write_reg_enable, write_reg, write_data); end
    step();
    checks++; if (write_reg_enable !== 1'b0 || write_reg !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL alu_hold got we=%0b reg=%0d data=%h exp 0/5/deadbeef", write_reg_enable, write_reg, write_data); end
  endtask

  task automatic test_lu_only();
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234_5678; step(); idle_inputs();
    checks++; if (lu_count !== 2'd1 || write_reg_enable !== 1'b0) begin
      failures++; $display("FAIL lu_accept got count=%0d we=%0b exp 1/0", lu_count, write_reg_enable); end
    step();
    checks++; if (write_reg_enable !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h1234_5678 || lu_count !== 2'd0) begin
      failures++; $display("FAIL lu_write got we=%0b reg=%0d data=%h count=%0d exp 1/7/12345678/0",
                           write_reg_enable, write_reg, write_data, lu_count); end
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] exp_seq [5];
    exp_seq[0] = 5'd9; exp_seq[1] = 5'd9; exp_seq[2] = 5'd9; exp_seq[3] = 5'd3; exp_seq[4] = 5'd4;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h0000_0033; step();
    lu_rd = 5'd4; lu_data = 32'h0000_0044;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
    for (int i = 0; i < 5; i++) begin
      step();
      lu_valid = 1'b0;
      if (i == 2) alu_valid = 1'b0;
      checks++; if (write_reg_enable !== 1'b1 || write_reg !== exp_seq[i]) begin
        failures++; $display("FAIL contention_seq idx=%0d got we=%0b reg=%0d exp 1/%0d", i, write_reg_enable, write_reg, exp_seq[i]); end
      if (i == 0) begin
        checks++; if (lu_count !== 2'd2 || lu_ready !== 1'b0) begin
          failures++; $display("FAIL contention_full got count=%0d ready=%0b exp 2/0", lu_count, lu_ready); end
      end
      if (i == 3) begin
        checks++; if (lu_ready !== 1'b1 || lu_count !== 2'd1) begin
          failures++; $display("FAIL contention_ready got ready=%0b count=%0d exp 1/1", lu_ready, lu_count); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_squash();
    lu_valid = 1'b1; lu_rd = 5'd6; lu_data = 32'd1; step(); idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'd2; step(); idle_inputs();
    checks++; if (write_reg_enable !== 1'b1 || write_reg !== 5'd6 || write_data !== 32'd2 || lu_count !== 2'd1) begin
      failures++; $display("FAIL squash_alu got we=%0b reg=%0d data=%h count=%0d exp 1/6/2/1",
                           write_reg_enable, write_reg, write_data, lu_count); end
    step();
    checks++; if (write_reg_enable !== 1'b0 || lu_count !== 2'd0 || write_data !== 32'd2) begin
      failures++; $display("FAIL squash_pop got we=%0b count=%0d data=%h exp 0/0/2", write_reg_enable, lu_count, write_data); end
  endtask

  task automatic test_x0();
    lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'h0000_0088; step(); idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_0BAD; step(); idle_inputs();
    checks++; if (write_reg_enable !== 1'b1 || write_reg !== 5'd8 || write_data !== 32'h0000_0088 || lu_count !== 2'd0) begin
      failures++; $display("FAIL x0_alu_drain got we=%0b reg=%0d data=%h count=%0d exp 1/8/88/0",
                           write_reg_enable, write_reg, write_data, lu_count); end
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h0000_0055; step(); idle_inputs();
    checks++; if (lu_count !== 2'd0 || lu_ready !== 1'b1 || write_reg_enable !== 1'b0) begin
      failures++; $display("FAIL x0_lu_drop got count=%0d ready=%0b we=%0b exp 0/1/0", lu_count, lu_ready, write_reg_enable); end
    step();
    checks++; if (write_reg_enable !== 1'b0) begin
      failures++; $display("FAIL x0_no_write got we=%0b exp 0", write_reg_enable); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      alu_valid = ($urandom_range(0, 99) < 45);
      alu_rd    = ADDR_W'($urandom_range(0, 7));
      alu_data  = $urandom;
      lu_valid  = ($urandom_range(0, 99) < 60);
      lu_rd     = ADDR_W'($urandom_range(0, 7));
      lu_data   = $urandom;
      step();
      checks++; if (write_reg_enable !== exp_we || write_reg !== exp_reg || write_data !== exp_data) begin
        failures++; $display("FAIL rand_write n=%0d got we=%0b reg=%0d data=%h exp %0b/%0d/%h",
                             n, write_reg_enable, write_reg, write_data, exp_we, exp_reg, exp_data); end
      checks++; if (lu_count !== q_rd.size() || lu_ready !== exp_ready) begin
        failures++; $display("FAIL rand_fifo n=%0d got count=%0d ready=%0b exp %0d/%0b",
                             n, lu_count, lu_ready, q_rd.size(), exp_ready); end
    end
    idle_inputs();
    for (int i = 0; i < DEPTH + 1; i++) step();
    checks++; if (lu_count !== 2'd0) begin
      failures++; $display("FAIL rand_drain got count=%0d exp 0", lu_count); end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_lu_only();
    test_contention();
    test_squash();
    test_x0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
